// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   ADDR_W / INST_W : instruction address and word widths
//   NOP_INST_DEF    : bubble word shown when IF/ID is empty
//   RESET_PC_DEF    : default first fetch address
//   fetch_state_e   : FETCH (requesting) / HOLD (skid full, no requests)
//   pc_inc          : 16-bit modulo PC increment
package if_fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] NOP_INST_DEF = 16'h0800;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Wraps 16'hFFFF to 16'h0000.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry holding register for a fetched word that arrived while decode
// was stalled. It is loaded on the acknowledge edge and read back (unloaded)
// combinationally when the stall releases.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_pc / load_inst this edge
//   skid_pc    : held IF/ID PC (fetch address + 1)
//   skid_inst  : held instruction word
module if_skid
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic [ADDR_W-1:0] skid_pc,
  output logic [INST_W-1:0] skid_inst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_pc   <= '0;
      skid_inst <= '0;
    end else if (load) begin
      skid_pc   <= load_pc;
      skid_inst <= load_inst;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, request/acknowledge with the
// instruction port of the memory controller, IF/ID output register, a
// one-entry skid for decode stalls and single-delay-slot branch redirect.
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : decode stall, IF/ID must not be replaced while high
//   branch_flag_i   : taken branch reported by decode (trusted on consume)
//   branch_addr_i   : branch target
//   mem_busy_i      : data side owns memory, suppresses the request
//   inst_req_o      : instruction read request
//   inst_addr_o     : instruction address (fetch_pc)
//   inst_ack_i      : read done, inst_data_i valid
//   inst_data_i     : fetched word
//   pc_o, inst_o    : IF/ID PC (address + 1) and instruction
//   valid_o         : IF/ID holds a real instruction
//   dbg_state       : current FSM state, for observation only
//
// Handshake: a read transfers on every rising edge where inst_req_o and
// inst_ack_i are both high. inst_addr_o is held constant from the first
// request cycle until that edge; an inst_ack_i while inst_req_o is low is
// ignored. On the decode side a word is consumed on every edge where
// valid_o is high and stall_i is low.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              mem_busy_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [INST_W-1:0] inst_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  output fetch_state_e      dbg_state
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
  logic              redir_pend, redir_pend_next;
  logic [ADDR_W-1:0] redir_addr, redir_addr_next;

  logic              ack, consume, slot_free, redirect;
  logic              skid_load;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              ifid_load, ifid_clear;
  logic [ADDR_W-1:0] ifid_pc_next;
  logic [INST_W-1:0] ifid_inst_next;

  assign inst_req_o  = !rst && (state == FETCH) && !mem_busy_i;
  assign inst_addr_o = fetch_pc;
  assign ack         = inst_req_o && inst_ack_i;
  assign consume     = valid_o && !stall_i;
  assign slot_free   = !valid_o || !stall_i;
  // A stalled branch is re-presented by decode, so only consume cycles count.
  assign redirect    = consume && branch_flag_i;
  assign dbg_state   = state;

  if_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .load_pc   (pc_inc(fetch_pc)),
    .load_inst (inst_data_i),
    .skid_pc   (skid_pc),
    .skid_inst (skid_inst)
  );

  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    redir_pend_next = redir_pend;
    redir_addr_next = redir_addr;
    skid_load       = 1'b0;
    ifid_load       = 1'b0;
    ifid_clear      = 1'b0;
    ifid_pc_next    = pc_inc(fetch_pc);
    ifid_inst_next  = inst_data_i;

    case (state)
      FETCH: begin
        if (ack) begin
          fetch_pc_next   = redir_pend ? redir_addr : pc_inc(fetch_pc);
          redir_pend_next = 1'b0;
          if (slot_free) begin
            ifid_load = 1'b1;
          end else begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end
          // The word arriving now is the delay slot: jump straight away.
          if (redirect) fetch_pc_next = branch_addr_i;
        end else begin
          if (consume) ifid_clear = 1'b1;
          // Delay slot still outstanding: remember the target for its ack.
          if (redirect) begin
            redir_pend_next = 1'b1;
            redir_addr_next = branch_addr_i;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          ifid_load      = 1'b1;
          ifid_pc_next   = skid_pc;
          ifid_inst_next = skid_inst;
          state_next     = FETCH;
          // The skid holds the delay slot; fetch_pc already points past it.
          if (redirect) fetch_pc_next = branch_addr_i;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      redir_pend <= 1'b0;
      redir_addr <= '0;
      pc_o       <= '0;
      inst_o     <= NOP_INST;
      valid_o    <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      redir_pend <= redir_pend_next;
      redir_addr <= redir_addr_next;
      if (ifid_load) begin
        pc_o    <= ifid_pc_next;
        inst_o  <= ifid_inst_next;
        valid_o <= 1'b1;
      end else if (ifid_clear) begin
        // pc_o deliberately keeps the last consumed PC.
        inst_o  <= NOP_INST;
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch. A reference model tracks the fetched but
// not yet consumed addresses as a queue plus the next program address, and
// predicts the request, address and IF/ID outputs every cycle.
module tb_if_fetch;

  localparam logic [15:0] NOP   = 16'h0800;
  localparam logic [15:0] RST_A = 16'h0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall_i = 1'b0, branch_flag_i = 1'b0, mem_busy_i = 1'b0;
  logic [15:0] branch_addr_i = '0;
  logic        inst_ack_i = 1'b0;
  logic [15:0] inst_data_i = '0;
  logic        inst_req_o, valid_o;
  logic [15:0] inst_addr_o, pc_o, inst_o;
  if_fetch_pkg::fetch_state_e dbg_state;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .mem_busy_i    (mem_busy_i),
    .inst_req_o    (inst_req_o),
    .inst_addr_o   (inst_addr_o),
    .inst_ack_i    (inst_ack_i),
    .inst_data_i   (inst_data_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o),
    .dbg_state     (dbg_state)
  );

  // ---------------- stimulus knobs ----------------
  logic        rst_drv = 1'b1;
  int unsigned stall_pct = 0, busy_pct = 0, br_pct = 0;
  int unsigned mem_mode = 0;   // 0: zero-wait, 1: two wait states, 2: random
  int unsigned wait_cnt = 0;

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q[$];       // fetched, not yet consumed (front = IF/ID)
  logic [15:0] next_addr = RST_A;
  logic [15:0] exp_pc = '0;
  logic        tgt_valid = 1'b0;
  logic [15:0] tgt_after = '0, tgt = '0;
  logic        delay_next = 1'b0;  // IF/ID front is a delay slot
  int          n_cmp = 0, n_err = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_addr  = RST_A;
    exp_pc     = '0;
    tgt_valid  = 1'b0;
    delay_next = 1'b0;
    wait_cnt   = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    logic        exp_req, ack_cnt, cons, br;
    logic        ack;
    logic [15:0] a;
    @(negedge clk);
    rst           = rst_drv;
    stall_i       = ($urandom_range(0, 99) < stall_pct);
    mem_busy_i    = ($urandom_range(0, 99) < busy_pct);
    branch_addr_i = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
    branch_flag_i = ($urandom_range(0, 99) < br_pct);
    // The program never branches from a delay slot.
    if (exp_q.size() > 0 && !stall_i && delay_next) branch_flag_i = 1'b0;
    #1;
    exp_req = !rst && !mem_busy_i && (exp_q.size() < 2);
    check("inst_req", inst_req_o, exp_req);
    if (exp_req) check("inst_addr", inst_addr_o, next_addr);

    // Memory reacts to the request it sees.
    if (inst_req_o) begin
      case (mem_mode)
        0:       ack = 1'b1;
        1:       ack = (wait_cnt == 2);
        default: ack = ($urandom_range(0, 2) == 0);
      endcase
      wait_cnt    = ack ? 0 : wait_cnt + 1;
      inst_ack_i  = ack;
      inst_data_i = ack ? mem_word(inst_addr_o) : 16'($urandom);
    end else begin
      inst_ack_i  = !rst && ($urandom_range(0, 3) == 0);  // stray, must be ignored
      inst_data_i = 16'($urandom);
    end

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      ack_cnt = exp_req && inst_ack_i;
      cons    = (exp_q.size() > 0) && !stall_i;
      br      = cons && branch_flag_i;
      if (ack_cnt) begin
        a = next_addr;
        exp_q.push_back(a);
        if (tgt_valid && a == tgt_after) begin
          next_addr = tgt;
          tgt_valid = 1'b0;
        end else begin
          next_addr = a + 16'd1;
        end
      end
      if (br) begin
        // Delay slot = the instruction after the branch; target follows it.
        if (exp_q.size() >= 2) next_addr = branch_addr_i;
        else begin
          tgt_valid = 1'b1;
          tgt_after = exp_q[0] + 16'd1;
          tgt       = branch_addr_i;
        end
      end
      if (cons) begin
        void'(exp_q.pop_front());
        delay_next = br;
      end
      if (exp_q.size() > 0) exp_pc = exp_q[0] + 16'd1;
    end

    #1;
    check("valid", valid_o, exp_q.size() > 0);
    check("pc", pc_o, exp_pc);
    if (exp_q.size() > 0) check("inst", inst_o, mem_word(exp_q[0]));
    else                  check("inst_nop", inst_o, NOP);
    check("hold_state", dbg_state, exp_q.size() == 2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic hit;
    model_reset();

    // Reset held: no request, reset values on IF/ID.
    rst_drv = 1'b1;
    repeat (2) cycle();

    // Zero-wait, no stalls: one instruction per cycle from RESET_PC.
    rst_drv = 1'b0;
    mem_mode = 0;
    repeat (8) cycle();

    // Two wait states: address held three request cycles, bubbles between.
    mem_mode = 1;
    repeat (15) cycle();

    // Long stall with zero-wait memory: skid fills once and then HOLD.
    mem_mode = 0;
    stall_pct = 100;
    repeat (6) cycle();
    stall_pct = 0;
    repeat (4) cycle();

    // Branches with zero-wait and wait-state memory, no stalls.
    br_pct = 25;
    repeat (40) cycle();
    mem_mode = 1;
    repeat (40) cycle();

    // Random mix of stalls, busy, branches and wait states.
    mem_mode  = 2;
    stall_pct = 30;
    busy_pct  = 15;
    br_pct    = 20;
    repeat (600) cycle();

    // Reset in the middle of a wait-state request.
    mem_mode  = 1;
    stall_pct = 0;
    busy_pct  = 0;
    br_pct    = 0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      hit = (wait_cnt == 1);
    end
    check("rst_window", hit, 1'b1);
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    repeat (10) cycle();

    // More random traffic after the mid-request reset.
    mem_mode  = 2;
    stall_pct = 25;
    busy_pct  = 20;
    br_pct    = 20;
    repeat (200) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
